// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: default geometry, FSM
// state encoding and the byte-merge helper used by the write and forward paths.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 256;

  // Widest word byte_merge handles; callers zero-extend and truncate around it.
  localparam int DMEM_MAX_W  = 256;
  localparam int DMEM_MAX_B  = DMEM_MAX_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  function automatic logic [DMEM_MAX_W-1:0] byte_merge(
    input logic [DMEM_MAX_W-1:0] old_word,
    input logic [DMEM_MAX_W-1:0] new_word,
    input logic [DMEM_MAX_B-1:0] mask
  );
    logic [DMEM_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < DMEM_MAX_B; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-to-data-memory bus: active-low selects, byte-masked write, read data
// and the responder's ready flag.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) ();

  logic                  dmem_csb_write_i;
  logic [DATA_W/8-1:0]   dmem_wmask_i;
  logic [ADDR_W-1:0]     dmem_waddr_i;
  logic [DATA_W-1:0]     dmem_din_i;
  logic                  dmem_csb_read_i;
  logic [ADDR_W-1:0]     dmem_raddr_i;
  logic [DATA_W-1:0]     dmem_dout_o;
  logic                  ready_o;

  modport master (
    output dmem_csb_write_i, dmem_wmask_i, dmem_waddr_i, dmem_din_i,
    output dmem_csb_read_i, dmem_raddr_i,
    input  dmem_dout_o, ready_o
  );

  modport slave (
    input  dmem_csb_write_i, dmem_wmask_i, dmem_waddr_i, dmem_din_i,
    input  dmem_csb_read_i, dmem_raddr_i,
    output dmem_dout_o, ready_o
  );

endinterface

// File: rtl/dmem_array.sv
// Storage for the data memory: one byte-masked write port and one registered
// read port, kept FSM-free so a foundry SRAM macro can replace it.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic                clk_i,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic              unused_addr_bits;

  // Callers only present in-range addresses, so the upper bits carry nothing.
  assign widx             = IDX_W'(waddr);
  assign ridx             = IDX_W'(raddr);
  assign unused_addr_bits = ^{waddr, raddr};

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[widx] <= DATA_W'(byte_merge(DMEM_MAX_W'(mem[widx]),
                                      DMEM_MAX_W'(wdata),
                                      DMEM_MAX_B'(wmask)));
    end
    if (re) begin
      rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data bus: zeroes the array after reset,
// then services byte-masked writes and pipelined reads (READ_LAT 1 or 2).
// Optional macro DMEM_WR_FWD_EN: same-address read/write collisions return write-first data.
//
//   state | meaning
//   CLEAR | sweeping clr_cnt over the array writing zeros; requests ignored
//   READY | requests serviced; left only through reset_i
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int READ_LAT = 1
) (
  input  logic     clk_i,
  input  logic     reset_i,
  dmem_if.slave    dmem
);

  localparam int                MASK_W    = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if ((DATA_W % 8) != 0 || DATA_W > DMEM_MAX_W) begin : g_bad_width
    $error("dmem_responder: DATA_W must be a multiple of 8 and <= DMEM_MAX_W");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("dmem_responder: READ_LAT must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be in 1..2**ADDR_W");
  end

  dmem_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

  logic                waddr_ok, raddr_ok;
  logic                wr_req, rd_req;
  logic                arr_we, arr_re;
  logic [ADDR_W-1:0]   arr_waddr;
  logic [MASK_W-1:0]   arr_wmask;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  logic                rd_v_q;
  logic                rd_oor_q;
  logic [DATA_W-1:0]   rd_raw;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   dout_q;

  assign waddr_ok = ({1'b0, dmem.dmem_waddr_i} < DEPTH_L);
  assign raddr_ok = ({1'b0, dmem.dmem_raddr_i} < DEPTH_L);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = dmem.dmem_waddr_i;
    arr_wmask = dmem.dmem_wmask_i;
    arr_wdata = dmem.dmem_din_i;

    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = READY;
        arr_we    = !reset_i;
        arr_waddr = clr_cnt_q;
        arr_wmask = '1;
        arr_wdata = '0;
      end
      READY: begin
        wr_req = !reset_i && !dmem.dmem_csb_write_i && waddr_ok;
        rd_req = !reset_i && !dmem.dmem_csb_read_i;
        arr_we = wr_req;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Out-of-range reads still occupy a pipeline slot so they return 0 on time.
  assign arr_re = rd_req && raddr_ok;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i (clk_i),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wmask (arr_wmask),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (dmem.dmem_raddr_i),
    .rdata (arr_rdata)
  );

`ifdef DMEM_WR_FWD_EN
  logic              fwd_q;
  logic [MASK_W-1:0] fwd_mask_q;
  logic [DATA_W-1:0] fwd_data_q;

  // The array returns old contents; overlay the colliding write one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_q      <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= rd_req && wr_req && (dmem.dmem_raddr_i == dmem.dmem_waddr_i);
      fwd_mask_q <= dmem.dmem_wmask_i;
      fwd_data_q <= dmem.dmem_din_i;
    end
  end

  assign rd_raw = fwd_q ? DATA_W'(byte_merge(DMEM_MAX_W'(arr_rdata),
                                             DMEM_MAX_W'(fwd_data_q),
                                             DMEM_MAX_B'(fwd_mask_q)))
                        : arr_rdata;
`else
  assign rd_raw = arr_rdata;
`endif

  assign rd_word = rd_oor_q ? '0 : rd_raw;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_v_q   <= 1'b0;
      rd_oor_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      rd_v_q   <= rd_req;
      rd_oor_q <= !raddr_ok;
      if (rd_v_q) dout_q <= rd_word;
    end
  end

  // dout_q doubles as the hold register for latency 1 and the output stage for latency 2.
  if (READ_LAT == 2) begin : g_lat2
    assign dmem.dmem_dout_o = dout_q;
  end else begin : g_lat1
    assign dmem.dmem_dout_o = rd_v_q ? rd_word : dout_q;
  end

  assign dmem.ready_o = (state_q == READY);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (READ_LAT 1 and 2) share
// one stimulus stream; per-instance monitors pop expected read data when due.
module tb_dmem_responder;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

`ifdef DMEM_WR_FWD_EN
  localparam logic [31:0] COLL_EXP = 32'h0000FFFF;
`else
  localparam logic [31:0] COLL_EXP = 32'h00000001;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          csb_w = 1'b1;
  logic          csb_r = 1'b1;
  logic [3:0]    wmask = '0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [31:0]   din   = '0;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  dmem_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  assign bus1.dmem_csb_write_i = csb_w;
  assign bus1.dmem_wmask_i     = wmask;
  assign bus1.dmem_waddr_i     = waddr;
  assign bus1.dmem_din_i       = din;
  assign bus1.dmem_csb_read_i  = csb_r;
  assign bus1.dmem_raddr_i     = raddr;
  assign bus2.dmem_csb_write_i = csb_w;
  assign bus2.dmem_wmask_i     = wmask;
  assign bus2.dmem_waddr_i     = waddr;
  assign bus2.dmem_din_i       = din;
  assign bus2.dmem_csb_read_i  = csb_r;
  assign bus2.dmem_raddr_i     = raddr;

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(1)) dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .dmem    (bus1)
  );

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(2)) dut2 (
    .clk_i   (clk),
    .reset_i (reset),
    .dmem    (bus2)
  );

  typedef struct {
    logic [31:0] ev;
    int          due;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e1 = q1.pop_front();
      chk(e1.name, bus1.dmem_dout_o, e1.ev);
    end
    while (q2.size() > 0 && q2[0].due <= cyc) begin
      e2 = q2.pop_front();
      chk(e2.name, bus2.dmem_dout_o, e2.ev);
    end
  end

  task automatic op(input bit we, input logic [AW-1:0] wa, input logic [31:0] wd,
                    input logic [3:0] wm, input bit re, input logic [AW-1:0] ra,
                    input bit push, input logic [31:0] ev, input string name);
    csb_w = !we;
    waddr = wa;
    din   = wd;
    wmask = wm;
    csb_r = !re;
    raddr = ra;
    if (re && push) begin
      q1.push_back('{ev: ev, due: cyc + 1, name: {name, "/lat1"}});
      q2.push_back('{ev: ev, due: cyc + 2, name: {name, "/lat2"}});
    end
    @(negedge clk);
    csb_w = 1'b1;
    csb_r = 1'b1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    op(1'b1, a, d, m, 1'b0, '0, 1'b0, '0, "");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] ev, input string name);
    op(1'b0, '0, '0, '0, 1'b1, a, 1'b1, ev, name);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    csb_w = 1'b1;
    csb_r = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready1", {31'b0, bus1.ready_o}, 32'd0);
    chk("rst_ready2", {31'b0, bus2.ready_o}, 32'd0);
    chk("rst_dout1", bus1.dmem_dout_o, 32'd0);
    chk("rst_dout2", bus2.dmem_dout_o, 32'd0);
    reset = 1'b0;
  endtask

  // Counts not-ready cycles from reset release; pokes the bus during CLEAR.
  task automatic count_ready(output int n);
    n = 0;
    while (!bus1.ready_o && n < 1000) begin
      if (n == 3) begin
        csb_w = 1'b0; waddr = 9'h005; din = 32'hDEADBEEF; wmask = 4'hF;
      end else if (n == 4) begin
        csb_w = 1'b0; waddr = 9'h002; din = 32'hDEADBEEF; wmask = 4'hF;
        csb_r = 1'b0; raddr = 9'h002;
      end else begin
        csb_w = 1'b1; csb_r = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    csb_w = 1'b1;
    csb_r = 1'b1;
    chk("clear_ready2", {31'b0, bus2.ready_o}, 32'd1);
    chk("clear_dout1", bus1.dmem_dout_o, 32'd0);
    chk("clear_dout2", bus2.dmem_dout_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    pulse_reset();
    count_ready(n);
    chk("ready_delay", 32'(n), 32'd256);

    rd(9'h010, 32'h0, "clr_10");
    rd(9'h005, 32'h0, "clr_wr05");
    rd(9'h002, 32'h0, "clr_wr02");

    wr(9'h020, 32'h11223344, 4'b1111);
    wr(9'h020, 32'hAABBCCDD, 4'b0101);
    rd(9'h020, 32'h11BB33DD, "mask");
    wr(9'h020, 32'hFFFFFFFF, 4'b0000);
    rd(9'h020, 32'h11BB33DD, "mask0");

    wr(9'h030, 32'h00000001, 4'b1111);
    op(1'b1, 9'h030, 32'hFFFFFFFF, 4'b0011, 1'b1, 9'h030, 1'b1, COLL_EXP, "collide");
    rd(9'h030, 32'h0000FFFF, "after_collide");

    op(1'b1, 9'h040, 32'hCAFEF00D, 4'b1111, 1'b1, 9'h020, 1'b1, 32'h11BB33DD, "diff_addr");
    rd(9'h040, 32'hCAFEF00D, "rd40");

    for (int i = 0; i < 4; i++) wr(AW'(i), 32'(i), 4'b1111);
    for (int i = 0; i < 4; i++) rd(AW'(i), 32'(i), $sformatf("b2b%0d", i));
    repeat (4) @(negedge clk);
    chk("hold1", bus1.dmem_dout_o, 32'd3);
    chk("hold2", bus2.dmem_dout_o, 32'd3);

    rd(9'h040, 32'hCAFEF00D, "pre_oor");
    rd(9'h150, 32'h0, "oor_rd");
    wr(9'h150, 32'h12345678, 4'b1111);
    rd(9'h050, 32'h0, "oor_alias");
    rd(9'h150, 32'h0, "oor_rd2");

    wr(9'h060, 32'h55AA55AA, 4'b1111);
    rd(9'h060, 32'h55AA55AA, "pre_rst");
    repeat (3) @(negedge clk);
    op(1'b0, '0, '0, '0, 1'b1, 9'h060, 1'b0, '0, "inflight");
    pulse_reset();
    repeat (100) @(negedge clk);
    pulse_reset();
    count_ready(n);
    chk("ready_delay_rst", 32'(n), 32'd256);
    rd(9'h060, 32'h0, "rst_clr60");
    rd(9'h020, 32'h0, "rst_clr20");

    repeat (4) @(negedge clk);
    chk("drain", 32'(q1.size() + q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
